// File: rtl/problema1_ocimem_pkg.sv
// Shared types and constants for the Nios II OCI RAM arbiter.
//   state_t : arbiter FSM states
//   jop_t   : JTAG command held in the pending latch
//   JDO_*   : bit positions of fields inside the 38-bit JTAG data word
package problema1_ocimem_pkg;

    localparam int JDO_W         = 38;
    localparam int JDO_RDEN      = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_ADDR_LSB  = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        J_CAP = 2'd1,
        C_CAP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } jop_t;

endpackage

// File: rtl/problema1_ocimem_jtag_cmd_latch.sv
// JTAG command latch: decodes the sysclk-domain action strobes into one
// pending command, keeps the JTAG word address, and flags overruns.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   jdo                        JTAG data word, valid with a strobe
//   take_action_ocimem_a/b,
//   take_no_action_ocimem_a    JTAG action strobes
//   cmd_done                   arbiter finished the pending read/write
//   pending                    a command is waiting or in flight
//   op                         latched command
//   wdata                      latched write data
//   jaddr                      current JTAG word address
//   overrun                    sticky: strobe seen while pending
module problema1_ocimem_jtag_cmd_latch
    import problema1_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              cmd_done,
    output logic              pending,
    output jop_t              op,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] jaddr,
    output logic              overrun
);

    logic strobe;
    assign strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // jdo bits outside the address/data/read-enable fields carry nothing here
    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RDEN+1], jdo[JDO_WDATA_LSB-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            op      <= NONE;
            wdata   <= '0;
            jaddr   <= '0;
            overrun <= 1'b0;
        end else begin
            if (strobe && pending) begin
                overrun <= 1'b1;
            end
            if (strobe && !pending) begin
                pending <= 1'b1;
                wdata   <= jdo[JDO_WDATA_LSB +: DATA_W];
                if (take_action_ocimem_b) begin
                    op <= WRITE;
                end else if (take_action_ocimem_a) begin
                    jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                    op    <= jdo[JDO_RDEN] ? READ : LOAD;
                end else begin
                    op <= READ;
                end
            end else if (pending && op == LOAD) begin
                // address already loaded at capture; nothing to arbitrate for
                pending <= 1'b0;
                op      <= NONE;
            end else if (cmd_done) begin
                pending <= 1'b0;
                op      <= NONE;
                jaddr   <= jaddr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/problema1_nios2_ocimem_arbiter.sv
// Shares the single-port OCI RAM (1-cycle read latency) between JTAG debug
// commands and the CPU Avalon-MM debug slave, round-robin on contention.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   jdo, take_*                      JTAG data word and action strobes
//   MonDReg, monitor_ready           JTAG read data / no command outstanding
//   jtag_overrun                     sticky strobe-while-busy flag
//   avs_*                            CPU Avalon-MM slave
//   ram_addr, ram_wren, ram_wdata    OCI RAM request
//   ram_q                            OCI RAM read data (1 cycle after ram_addr)
//
// state | meaning
// IDLE  | arbitrate; writes complete here in one cycle
// J_CAP | ram_q holds JTAG read data, load MonDReg
// C_CAP | ram_q holds CPU read data, complete the Avalon read
module problema1_nios2_ocimem_arbiter
    import problema1_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            state;
    logic              last_grant_jtag;
    logic              pending;
    jop_t              op;
    logic [DATA_W-1:0] jwdata;
    logic [ADDR_W-1:0] jaddr;
    logic              cmd_done;
    logic              j_req;
    logic              c_req;
    logic              grant_j;
    logic              grant_c;

    problema1_ocimem_jtag_cmd_latch #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_cmd_latch (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cmd_done                (cmd_done),
        .pending                 (pending),
        .op                      (op),
        .wdata                   (jwdata),
        .jaddr                   (jaddr),
        .overrun                 (jtag_overrun)
    );

    // Requests are masked during reset so a held CPU write cannot reach the RAM.
    assign j_req = reset_n && pending && (op == READ || op == WRITE);
    assign c_req = reset_n && (avs_read || avs_write);

    always_comb begin
        grant_j = 1'b0;
        grant_c = 1'b0;
        if (state == IDLE) begin
            if (j_req && c_req) begin
                grant_j = !last_grant_jtag;
                grant_c = last_grant_jtag;
            end else begin
                grant_j = j_req;
                grant_c = c_req;
            end
        end
    end

    // A simultaneous avs_read/avs_write is treated as a write.
    assign ram_addr        = grant_c ? avs_address : jaddr;
    assign ram_wdata       = grant_c ? avs_writedata : jwdata;
    assign ram_wren        = (grant_j && op == WRITE) || (grant_c && avs_write);
    assign avs_waitrequest = !((grant_c && avs_write) || state == C_CAP);
    assign avs_readdata    = (state == C_CAP) ? ram_q : '0;
    assign cmd_done        = (grant_j && op == WRITE) || state == J_CAP;
    assign monitor_ready   = !pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            last_grant_jtag <= 1'b0;
            MonDReg         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_j) begin
                        last_grant_jtag <= 1'b1;
                        if (op == READ) begin
                            state <= J_CAP;
                        end
                    end else if (grant_c) begin
                        last_grant_jtag <= 1'b0;
                        if (!avs_write) begin
                            state <= C_CAP;
                        end
                    end
                end
                J_CAP: begin
                    MonDReg <= ram_q;
                    state   <= IDLE;
                end
                C_CAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_problema1_nios2_ocimem_arbiter.sv
module tb_problema1_nios2_ocimem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_q;

    int checks;
    int failures;
    int wren_count;

    logic [31:0] mem [256];

    problema1_nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_q                   (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port RAM model, registered read
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    always @(posedge clk) begin
        if (ram_wren) wren_count <= wren_count + 1;
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_waits;
    } cpu_vec_t;

    cpu_vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
        logic [37:0] v;
        v = '0;
        v[34] = rd;
        v[33:26] = a;
        return v;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a; one-cycle strobe
    task automatic jtag(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = '0;
    endtask

    task automatic cpu_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int waits);
        avs_address   = a;
        avs_write     = wr;
        avs_read      = !wr;
        avs_writedata = d;
        waits = 0;
        #1;
        while (avs_waitrequest && waits < 20) begin
            waits++;
            tick();
        end
        rd = avs_readdata;
        tick();
    endtask

    task automatic cpu_idle();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!monitor_ready && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'd0, monitor_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          waits;
        int          wren_before;

        checks = 0;
        failures = 0;
        wren_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h11] = 32'h1111_1111;
        mem[8'h00] = 32'hC0DE_0000;

        vecs[0] = '{1'b1, 8'h20, 32'h0000_0001, 32'h0, 0};
        vecs[1] = '{1'b1, 8'h21, 32'h0000_0002, 32'h0, 0};
        vecs[2] = '{1'b1, 8'h22, 32'h0000_0003, 32'h0, 0};
        vecs[3] = '{1'b1, 8'h23, 32'h0000_0004, 32'h0, 0};
        vecs[4] = '{1'b0, 8'h20, 32'h0, 32'h0000_0001, 1};
        vecs[5] = '{1'b0, 8'h21, 32'h0, 32'h0000_0002, 1};
        vecs[6] = '{1'b0, 8'h22, 32'h0, 32'h0000_0003, 1};
        vecs[7] = '{1'b0, 8'h23, 32'h0, 32'h0000_0004, 1};
        vecs[8] = '{1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1};

        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // reset state
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready", {31'd0, monitor_ready}, 32'd1);
        check("rst_overrun", {31'd0, jtag_overrun}, 32'd0);
        check("rst_wren", {31'd0, ram_wren}, 32'd0);
        check("rst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
        check("rst_readdata", avs_readdata, 32'h0);

        // contention with last_grant=CPU: JTAG read first, CPU waits 3 cycles
        jtag(0, jdo_a(8'h30, 1'b1));
        check("cont1_ready_low", {31'd0, monitor_ready}, 32'd0);
        cpu_xfer(1'b0, 8'h40, 32'h0, rd, waits);
        cpu_idle();
        check("cont1_cpu_waits", 32'(waits), 32'd3);
        check("cont1_cpu_data", rd, 32'hA500_0040);
        check("cont1_mondreg", MonDReg, 32'hA500_0030);
        check("cont1_ready", {31'd0, monitor_ready}, 32'd1);

        // JTAG read latency: MonDReg updated two cycles after the strobe
        jtag(0, jdo_a(8'h10, 1'b1));
        tick();
        check("jrd_early", MonDReg, 32'hA500_0030);
        tick();
        check("jrd_data", MonDReg, 32'hDEAD_BEEF);
        check("jrd_ready", {31'd0, monitor_ready}, 32'd1);
        jtag(2, '0);
        wait_ready("jrd_inc_timeout");
        check("jrd_inc_data", MonDReg, 32'h1111_1111);

        // contention with last_grant=JTAG: CPU first
        jtag(2, '0);
        cpu_xfer(1'b0, 8'h41, 32'h0, rd, waits);
        cpu_idle();
        check("cont2_cpu_waits", 32'(waits), 32'd1);
        check("cont2_cpu_data", rd, 32'hA500_0041);
        wait_ready("cont2_timeout");
        check("cont2_mondreg", MonDReg, 32'hA500_0012);

        // address load only, then write at 0xFF and wrap
        wren_before = wren_count;
        jtag(0, jdo_a(8'hFF, 1'b0));
        check("load_busy", {31'd0, monitor_ready}, 32'd0);
        tick();
        check("load_done", {31'd0, monitor_ready}, 32'd1);
        check("load_no_wren", 32'(wren_count - wren_before), 32'd0);
        jtag(1, jdo_b(32'h1234_5678));
        check("jwr_wren", {31'd0, ram_wren}, 32'd1);
        check("jwr_addr", {24'd0, ram_addr}, 32'h0000_00FF);
        check("jwr_wdata", ram_wdata, 32'h1234_5678);
        tick();
        check("jwr_pulse", {31'd0, ram_wren}, 32'd0);
        jtag(2, '0);
        wait_ready("wrap_timeout");
        check("wrap_data", MonDReg, 32'hC0DE_0000);
        cpu_xfer(1'b0, 8'hFF, 32'h0, rd, waits);
        cpu_idle();
        check("jwr_readback", rd, 32'h1234_5678);

        // back-to-back CPU writes then reads
        wren_before = wren_count;
        for (int i = 0; i < 9; i++) begin
            cpu_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, waits);
            check($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
            if (!vecs[i].wr) check($sformatf("vec%0d_data", i), rd, vecs[i].exp_rdata);
        end
        cpu_idle();
        check("vec_wren_pulses", 32'(wren_count - wren_before), 32'd4);

        // overrun: second strobe while the write is still pending
        jtag(1, jdo_b(32'hCAFE_F00D));
        check("ovr_before", {31'd0, jtag_overrun}, 32'd0);
        jtag(2, '0);
        check("ovr_set", {31'd0, jtag_overrun}, 32'd1);
        tick();
        tick();
        tick();
        check("ovr_dropped_ready", {31'd0, monitor_ready}, 32'd1);
        check("ovr_dropped_data", MonDReg, 32'hC0DE_0000);
        cpu_xfer(1'b0, 8'h01, 32'h0, rd, waits);
        cpu_idle();
        check("ovr_write_ok", rd, 32'hCAFE_F00D);
        jtag(2, '0);
        wait_ready("ovr_next_timeout");
        check("ovr_next_data", MonDReg, 32'hA500_0002);
        check("ovr_sticky", {31'd0, jtag_overrun}, 32'd1);

        // reset while in J_CAP
        jtag(0, jdo_a(8'h10, 1'b1));
        tick();
        wren_before = wren_count;
        reset_n = 1'b0;
        #1;
        check("mrst_mondreg", MonDReg, 32'h0);
        check("mrst_ready", {31'd0, monitor_ready}, 32'd1);
        check("mrst_wren", {31'd0, ram_wren}, 32'd0);
        check("mrst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
        check("mrst_overrun", {31'd0, jtag_overrun}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("mrst_no_capture", MonDReg, 32'h0);
        check("mrst_no_wren", 32'(wren_count - wren_before), 32'd0);
        cpu_xfer(1'b1, 8'h50, 32'h5555_AAAA, rd, waits);
        cpu_idle();
        check("post_rst_wr_waits", 32'(waits), 32'd0);
        cpu_xfer(1'b0, 8'h50, 32'h0, rd, waits);
        cpu_idle();
        check("post_rst_rd", rd, 32'h5555_AAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
